// File: rtl/botones_pkg.sv
// Shared types and PIO register map for the button IRQ servicer.
package botones_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        READ,
        WAIT,
        CLEAR,
        PUSH
    } state_t;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/botones_evt_counter.sv
// Per-button saturating event counters (8 bits each), bumped on every
// accepted event whose bit is set.
module botones_evt_counter
    import botones_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inc,
    input  logic [WIDTH-1:0]   bits,
    output logic [WIDTH*8-1:0] count
);

    logic [WIDTH-1:0][7:0] cnt;

    // One counter per button, holding at 255 instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (inc && bits[i] && (cnt[i] != 8'hFF))
                    cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    assign count = cnt;

endmodule

// File: rtl/botones_irq_servicer.sv
// Avalon-MM master servicing the button PIO: programs the IRQ mask once after
// reset, then on each irq reads edge capture, clears it and offers the
// captured bits over a valid/ready handshake.
// Optional build macro BOTONES_SRV_CNT_EN adds per-button event counters
// on output evt_count.
module botones_irq_servicer
    import botones_pkg::*;
#(
    parameter int unsigned      WIDTH        = 2,
    parameter logic [WIDTH-1:0] MASK_INIT    = {WIDTH{1'b1}},
    parameter int unsigned      READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               irq,
    output logic [1:0]         avm_address,
    output logic               avm_chipselect,
    output logic               avm_write_n,
    output logic [31:0]        avm_writedata,
    input  logic [31:0]        avm_readdata,
    output logic               evt_valid,
    output logic [WIDTH-1:0]   evt_bits,
    input  logic               evt_ready
`ifdef BOTONES_SRV_CNT_EN
    ,
    output logic [WIDTH*8-1:0] evt_count
`endif
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_last;
    logic             unused_rd;

    // Only the low WIDTH bits of readdata carry edge-capture state.
    assign unused_rd = ^avm_readdata;
    assign wait_last = (wait_cnt == CNT_W'(READ_LATENCY - 1));

    // Service FSM; bus and event outputs are registered together with the
    // state so each state's bus cycle is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= INIT;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= PIO_ADDR_DATA;
            avm_writedata  <= '0;
            evt_valid      <= 1'b0;
            evt_bits       <= '0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                INIT: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= PIO_ADDR_MASK;
                    avm_writedata  <= 32'(MASK_INIT);
                    state          <= IDLE;
                end
                IDLE: begin
                    avm_write_n <= 1'b1;
                    if (irq && enable) begin
                        avm_chipselect <= 1'b1;
                        avm_address    <= PIO_ADDR_EDGE;
                        state          <= READ;
                    end else begin
                        avm_chipselect <= 1'b0;
                    end
                end
                READ: begin
                    avm_chipselect <= 1'b0;
                    wait_cnt       <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (wait_last) begin
                        evt_bits       <= avm_readdata[WIDTH-1:0];
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_writedata  <= '0;
                        state          <= CLEAR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    // An irq with nothing captured is dropped silently.
                    if (|evt_bits) begin
                        evt_valid <= 1'b1;
                        state     <= PUSH;
                    end else begin
                        state <= IDLE;
                    end
                end
                PUSH: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef BOTONES_SRV_CNT_EN
    botones_evt_counter #(.WIDTH(WIDTH)) u_evt_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (evt_valid && evt_ready),
        .bits    (evt_bits),
        .count   (evt_count)
    );
`endif

endmodule
